// File: rtl/datapath_result_collector.sv
// Observes a fixed-latency datapath, re-pairs each result with its issued operands and
// queues them in a first-word-fall-through FIFO. Define COLLECTOR_STATS_EN to add drop/push counters.
module datapath_result_collector #(
    parameter int N     = 16,
    parameter int pipe  = 1,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [N-1:0]          A,
    input  logic signed [N-1:0]          B,
    input  logic [2:0]                   opcode,
    input  logic signed [N-1:0]          Y,
    input  logic                         co,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 out_A,
    output logic [N-1:0]                 out_B,
    output logic [2:0]                   out_opcode,
    output logic [N-1:0]                 out_Y,
    output logic                         out_co,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [7:0]                   drop_count,
    output logic [15:0]                  push_total
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } tag_t;

    typedef struct packed {
        tag_t         tag;
        logic [N-1:0] y;
        logic         co;
    } entry_t;

    tag_t   tag_in;
    tag_t   tag_dly;
    logic   vld_dly;

    assign tag_in = '{a: A, b: B, op: opcode};

    // Tag delay line: only the valid bits need reset, the payload follows them.
    generate
        if (pipe == 0) begin : g_nopipe
            assign vld_dly = in_valid;
            assign tag_dly = tag_in;
        end else begin : g_pipe
            logic [pipe:1] vld_pipe;
            tag_t          tag_pipe [1:pipe];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[1] <= in_valid;
                    for (int i = 2; i <= pipe; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            always_ff @(posedge clk) begin
                tag_pipe[1] <= tag_in;
                for (int i = 2; i <= pipe; i++) tag_pipe[i] <= tag_pipe[i-1];
            end

            assign vld_dly = vld_pipe[pipe];
            assign tag_dly = tag_pipe[pipe];
        end
    endgenerate

    // Blocks a push on the first edge after reset release (matters for the zero-latency case).
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            drop;

    assign push   = vld_dly & armed;
    assign pop    = out_valid & out_ready;
    assign full   = (count == CW'(DEPTH));
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= '{tag: tag_dly, y: Y, co: co};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    entry_t head;

    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_A      = out_valid ? head.tag.a  : '0;
    assign out_B      = out_valid ? head.tag.b  : '0;
    assign out_opcode = out_valid ? head.tag.op : '0;
    assign out_Y      = out_valid ? head.y      : '0;
    assign out_co     = out_valid ? head.co     : 1'b0;

`ifdef COLLECTOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            push_total <= '0;
        end else begin
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (accept)                      push_total <= push_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datapath_result_collector.sv
// Bench for datapath_result_collector: four configurations share one operand stream, a queue-based
// model tracks each FIFO, directed tables cover the latency/ordering/full/reset corners.
module tb_datapath_result_collector;

    localparam int NI = 4;
    localparam int P [NI] = '{1, 2, 1, 0};
    localparam int D [NI] = '{8, 8, 4, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [15:0] A = '0, B = '0, ry = '0;
    logic [2:0] opcode = '0;
    logic rco = 1'b0;

    always #5 clk = ~clk;

    // Emulated datapath: result issued with the operands re-appears pipe edges later.
    logic [16:0] h1, h2;
    always @(posedge clk) begin
        h1 <= {ry, rco};
        h2 <= h1;
    end

    logic signed [15:0] yv [NI];
    logic               cv [NI];
    always_comb begin
        {yv[0], cv[0]} = h1;
        {yv[1], cv[1]} = h2;
        {yv[2], cv[2]} = h1;
        {yv[3], cv[3]} = {ry, rco};
    end

    logic        ov [NI];
    logic [15:0] oa [NI], ob [NI], oy [NI];
    logic [2:0]  oop [NI];
    logic        oco [NI];
    logic        of [NI];
    logic [3:0]  c0, c1;
    logic [2:0]  c2, c3;
    int          cnt [NI];
`ifdef COLLECTOR_STATS_EN
    logic [7:0]  dc [NI];
    logic [15:0] pt [NI];
`endif

    always_comb begin
        cnt[0] = int'(c0);
        cnt[1] = int'(c1);
        cnt[2] = int'(c2);
        cnt[3] = int'(c3);
    end

    datapath_result_collector #(.N(16), .pipe(1), .DEPTH(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .Y(yv[0]), .co(cv[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_A(oa[0]),
        .out_B(ob[0]), .out_opcode(oop[0]), .out_Y(oy[0]), .out_co(oco[0]), .count(c0),
        .overflow(of[0])
`ifdef COLLECTOR_STATS_EN
        , .drop_count(dc[0]), .push_total(pt[0])
`endif
    );
    datapath_result_collector #(.N(16), .pipe(2), .DEPTH(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .Y(yv[1]), .co(cv[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_A(oa[1]),
        .out_B(ob[1]), .out_opcode(oop[1]), .out_Y(oy[1]), .out_co(oco[1]), .count(c1),
        .overflow(of[1])
`ifdef COLLECTOR_STATS_EN
        , .drop_count(dc[1]), .push_total(pt[1])
`endif
    );
    datapath_result_collector #(.N(16), .pipe(1), .DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .Y(yv[2]), .co(cv[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_A(oa[2]),
        .out_B(ob[2]), .out_opcode(oop[2]), .out_Y(oy[2]), .out_co(oco[2]), .count(c2),
        .overflow(of[2])
`ifdef COLLECTOR_STATS_EN
        , .drop_count(dc[2]), .push_total(pt[2])
`endif
    );
    datapath_result_collector #(.N(16), .pipe(0), .DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .Y(yv[3]), .co(cv[3]), .out_valid(ov[3]), .out_ready(out_ready), .out_A(oa[3]),
        .out_B(ob[3]), .out_opcode(oop[3]), .out_Y(oy[3]), .out_co(oco[3]), .count(c3),
        .overflow(of[3])
`ifdef COLLECTOR_STATS_EN
        , .drop_count(dc[3]), .push_total(pt[3])
`endif
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each issue is scheduled to land pipe edges later; FIFO is a bounded queue.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] y;
        logic        co;
    } ent_t;
    typedef struct {
        int   due;
        ent_t e;
    } pend_t;

    ent_t  fq [NI][$];
    pend_t pq [NI][$];
    logic  movf [NI];
    int    mdrop [NI];
    int    mpush [NI];
    bit    first_edge;
    int    cyc = 0;

    task automatic model_edge();
        pend_t p;
        bit    do_pop;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                fq[k].delete();
                pq[k].delete();
                movf[k]  = 1'b0;
                mdrop[k] = 0;
                mpush[k] = 0;
            end
            first_edge = 1'b1;
        end else begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                do_pop = (fq[k].size() > 0) && out_ready;
                if (in_valid) pq[k].push_back('{cyc + P[k], '{A, B, opcode, ry, rco}});
                if (do_pop) void'(fq[k].pop_front());
                if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                    p = pq[k].pop_front();
                    if (!first_edge) begin
                        if (fq[k].size() < D[k]) begin
                            fq[k].push_back(p.e);
                            mpush[k]++;
                        end else begin
                            movf[k] = 1'b1;
                            if (mdrop[k] < 255) mdrop[k]++;
                        end
                    end
                end
            end
            first_edge = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_edge();

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("mon%0d valid", k), 64'(ov[k]), 64'(fq[k].size() > 0));
            chk($sformatf("mon%0d count", k), 64'(cnt[k]), 64'(fq[k].size()));
            chk($sformatf("mon%0d overflow", k), 64'(of[k]), 64'(movf[k]));
            if (fq[k].size() > 0)
                chk($sformatf("mon%0d head", k), 64'({oa[k], ob[k], oop[k], oy[k], oco[k]}),
                    64'(fq[k][0]));
`ifdef COLLECTOR_STATS_EN
            chk($sformatf("mon%0d drop_count", k), 64'(dc[k]), 64'(mdrop[k]));
            chk($sformatf("mon%0d push_total", k), 64'(pt[k]), 64'(mpush[k] & 16'hFFFF));
`endif
        end
    end

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [2:0]         op;
        logic signed [15:0] y;
        logic               co;
    } vec_t;

    vec_t tbl [6];

    task automatic issue(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        A = v.a; B = v.b; opcode = v.op; ry = v.y; rco = v.co;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_head(input int k, input string nm, input vec_t v);
        chk(nm, 64'({oa[k], ob[k], oop[k], oy[k], oco[k]}), 64'({v.a, v.b, v.op, v.y, v.co}));
    endtask

    task automatic pop_one();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_cleared(input int k, input string nm);
        chk({nm, " valid"}, 64'(ov[k]), 64'd0);
        chk({nm, " count"}, 64'(cnt[k]), 64'd0);
        chk({nm, " overflow"}, 64'(of[k]), 64'd0);
        chk({nm, " fields"}, 64'({oa[k], ob[k], oop[k], oy[k], oco[k]}), 64'd0);
    endtask

    initial begin
        int readyp;
        tbl[0] = '{16'sd5,      16'sd3,    3'b000, 16'sd8,      1'b0};
        tbl[1] = '{-16'sd7,     16'sd2,    3'b001, -16'sd5,     1'b1};
        tbl[2] = '{16'sh7FFF,   16'sd1,    3'b111, 16'sh8000,   1'b0};
        tbl[3] = '{16'sh1234,   16'sh00FF, 3'b010, 16'sh1133,   1'b1};
        tbl[4] = '{-16'sd1,     -16'sd1,   3'b011, -16'sd2,     1'b1};
        tbl[5] = '{16'sh0A0A,   16'sh5050, 3'b101, 16'sh5A5A,   1'b0};

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk_cleared(k, $sformatf("reset%0d", k));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-result latency and signed round-trip on the pipe=1 instance.
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i]);
            idle();
            chk($sformatf("lat%0d pre count", i), 64'(cnt[0]), 64'd0);
            @(posedge clk); #2;
            chk($sformatf("lat%0d valid", i), 64'(ov[0]), 64'd1);
            chk($sformatf("lat%0d count", i), 64'(cnt[0]), 64'd1);
            chk_head(0, $sformatf("lat%0d head", i), tbl[i]);
            pop_one();
        end
        @(negedge clk); out_ready = 1'b1;
        repeat (4) @(negedge clk);
        out_ready = 1'b0;

        // Back-to-back issue into the pipe=2 instance, then drain in order.
        for (int i = 3; i < 6; i++) issue(tbl[i]);
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("order count", 64'(cnt[1]), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk_head(1, $sformatf("order head%0d", i), tbl[3+i]);
            pop_one();
        end
        chk("order drained", 64'(cnt[1]), 64'd0);

        // Five results into a four-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 5; i++) issue(tbl[i]);
        idle();
        @(posedge clk); #2;
        chk("full count", 64'(cnt[2]), 64'd4);
        chk("full overflow", 64'(of[2]), 64'd1);
`ifdef COLLECTOR_STATS_EN
        chk("full drop_count", 64'(dc[2]), 64'd1);
        chk("full push_total", 64'(pt[2]), 64'd4);
`endif
        for (int i = 0; i < 4; i++) begin
            chk_head(2, $sformatf("full head%0d", i), tbl[i]);
            pop_one();
        end
        chk("full fifth absent", 64'(cnt[2]), 64'd0);

        // Push into a full FIFO on the same edge as a pop.
        do_reset();
        for (int i = 0; i < 4; i++) issue(tbl[i]);
        idle();
        @(posedge clk); #2;
        chk("pp full count", 64'(cnt[2]), 64'd4);
        issue(tbl[5]);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("pp count", 64'(cnt[2]), 64'd4);
        chk("pp overflow", 64'(of[2]), 64'd0);
        @(negedge clk); out_ready = 1'b0;
        chk_head(2, "pp head0", tbl[1]);
        pop_one();
        chk_head(2, "pp head1", tbl[2]);
        pop_one();
        chk_head(2, "pp head2", tbl[3]);
        pop_one();
        chk_head(2, "pp tail", tbl[5]);
        pop_one();

        // Reset between issue and result with two stored entries.
        issue(tbl[0]);
        issue(tbl[1]);
        idle();
        @(posedge clk); #2;
        chk("rst stored", 64'(cnt[0]), 64'd2);
        issue(tbl[2]);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cleared(0, "rst mid0");
        chk_cleared(3, "rst mid3");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        A = tbl[4].a; B = tbl[4].b; opcode = tbl[4].op; ry = tbl[4].y; rco = tbl[4].co;
        @(posedge clk); #2;
        chk("rst first edge pipe0", 64'(cnt[3]), 64'd0);
        chk("rst first edge pipe1", 64'(cnt[0]), 64'd0);
        idle();
        @(posedge clk); #2;
        chk("rst fresh count", 64'(cnt[0]), 64'd1);
        chk_head(0, "rst fresh head", tbl[4]);
        @(posedge clk); #2;
        chk("rst no stale pipe2", 64'(cnt[1]), 64'd1);
        chk_head(1, "rst fresh head pipe2", tbl[4]);

        // Randomized traffic with varying consumer rate and occasional resets.
        readyp = 50;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) readyp = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 90 : 50);
            rst_n     = ($urandom_range(0, 599) != 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            A         = 16'($urandom);
            B         = 16'($urandom);
            opcode    = 3'($urandom);
            ry        = 16'($urandom);
            rco       = 1'($urandom);
            out_ready = ($urandom_range(0, 99) < readyp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/datapath_result_collector.md
DATAPATH_RESULT_COLLECTOR -- requirements
Module: datapath_result_collector

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter pipe, default 1, meaning the datapath latency in clock cycles (0..4).
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning result FIFO entries (power of two, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands A/B/opcode are issued to the datapath this cycle.
REQ-007 The block SHALL have ports A and B, input, N bits signed: the operands issued to the datapath.
REQ-008 The block SHALL have port opcode, input, 3 bits: the opcode issued to the datapath.
REQ-009 The block SHALL have ports Y (input, N bits signed) and co (input, 1 bit): the datapath result and carry.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the FIFO head entry is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 The block SHALL have ports out_A and out_B (output, N bits), out_opcode (output, 3 bits), out_Y (output, N bits) and out_co (output, 1 bit): the head-entry fields.
REQ-013 The block SHALL have port count, output, clog2(DEPTH+1) bits: number of occupied FIFO entries.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a result is dropped.

Function
REQ-015 The block SHALL delay {in_valid, A, B, opcode} through exactly pipe register stages so that the tag aligns with the matching Y/co.
REQ-016 With pipe=0 the block SHALL use no tag registers and push in the same cycle as in_valid.
REQ-017 A push SHALL occur on a clock edge where the delayed valid is 1, writing {tag A, tag B, tag opcode, Y, co} as sampled at that edge.
REQ-018 A pop SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-019 The FIFO SHALL be first-word-fall-through: the head fields SHALL be visible on out_* in the cycle after the push, and out_valid SHALL be 1 whenever count>0.
REQ-020 out_* fields SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Push while not full SHALL increment count; pop while not pushing SHALL decrement count; a simultaneous push and pop SHALL leave count unchanged.
REQ-022 Push while full without a pop SHALL discard the entry, leave the FIFO contents unchanged and set overflow=1.
REQ-023 Push while full with a simultaneous pop SHALL be accepted with no overflow.
REQ-024 A pop while empty SHALL be impossible, because out_valid=0; out_ready SHALL be ignored while the FIFO is empty.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 overflow SHALL remain set until reset.
REQ-027 The block SHALL be a pure observer: it SHALL NOT drive the datapath or backpressure in_valid.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all tag-stage valids, pointers and count, set out_valid=0 and overflow=0, and drive out_A, out_B, out_opcode, out_Y and out_co to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight tags and stored entries, and no push SHALL occur on the first edge after deassertion.

Configuration
REQ-030 When macro COLLECTOR_STATS_EN is defined, the block SHALL add output drop_count (8 bits, saturates at 255, increments per discarded push) and output push_total (16 bits, wrapping, increments per accepted push), both reset to 0.
REQ-031 When COLLECTOR_STATS_EN is undefined, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 With pipe=1, drive in_valid=1, A=5, B=3, opcode=000 at edge k, then Y=8, co=0 at edge k+1 -> out_valid=1 after edge k+1 with out_A=5, out_B=3, out_Y=8, out_co=0, and count=1.
REQ-033 With pipe=2, send 3 back-to-back operations while out_ready=0 -> count=3 and entries pop in issue order with correct A/B/opcode/Y pairing.
REQ-034 With DEPTH=4 and out_ready=0, send 5 operations -> count=4, overflow=1, and the 5th entry is absent; with COLLECTOR_STATS_EN, drop_count=1 and push_total=4.
REQ-035 With a full FIFO, out_ready=1 and a push on the same edge -> count stays 4, overflow stays 0, and the new entry lands at the tail.
REQ-036 With pipe=1 and A=-7, B=2, Y=-5, co=1 -> signed values round-trip unchanged on out_A, out_Y and out_co.
REQ-037 Assert rst_n=0 between issue and result with 2 entries stored -> out_valid=0, count=0 and overflow=0 immediately, and no stale push after release.
